oak_constant_server: RTL and testbench
======================================

Name: oak_constant_server

Overview:
- Shares the L1 sacred-constant source (oak_foundation) between N_REQ requesters.
- Each requester asks for one constant by selector. A round-robin arbiter grants one request per cycle.
- The chosen constant is returned through a registered, back-pressurable response port tagged with the requester ID.
- Sits between oak_foundation and the higher Matryoshka layers, which consume φ, π, e, 3 and phoenix_id.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester tag; must satisfy 2^ID_W >= N_REQ.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request strobe.
- req_sel  in  3*N_REQ  per-requester selector; requester i uses bits [3i+2:3i].
- req_ready  out  N_REQ  one-hot grant; a request is accepted when req_valid[i] and req_ready[i] are both high.
- rsp_valid  out  1  response register holds valid data.
- rsp_ready  in  1  downstream accepts the response.
- rsp_id  out  ID_W  index of the requester being served.
- rsp_data  out  64  constant value.
- rsp_err  out  1  selector was out of range.
- served_cnt  out  32  count of completed response handshakes.

Behaviour:
- Clock/reset: one clock (clk); rst is synchronous and active-high.
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, served_cnt=0. The round-robin pointer resets so requester 0 has highest priority.
- Selector map:
  - 0 = phi 64'h3FF9E3779B97F4A8
  - 1 = pi 64'h400921FB54442D18
  - 2 = e 64'h4005BF0A8B145769
  - 3 = trinity 64'h4008000000000000
  - 4 = phoenix_id, zero-extended to 64 bits (64'd999)
  - 5..7 = invalid: rsp_data=0, rsp_err=1
- Accept enable: acc_en = !rsp_valid || rsp_ready. This gives a one-entry pipeline with no bubble under continuous rsp_ready.
- Arbitration (combinational):
  - Search req_valid starting at index ptr, wrapping modulo N_REQ.
  - The first set bit wins.
  - req_ready = onehot(winner) when acc_en and any req_valid is set; otherwise req_ready = 0.
  - req_ready never asserts for a requester whose req_valid is low.
- On accept (rising edge):
  - Load rsp_data, rsp_err and rsp_id=winner.
  - Set rsp_valid=1.
  - ptr <= (winner+1) mod N_REQ.
- Latency: exactly 1 cycle from the accept edge to rsp_valid.
- Response register states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - EMPTY→FULL on accept.
  - FULL→EMPTY on rsp_valid && rsp_ready with no new accept.
  - FULL→FULL on a handshake plus a same-cycle accept (the register is overwritten with the new data).
  - FULL held while rsp_ready=0; rsp_id, rsp_data and rsp_err stay stable, and req_ready stays all-zero.
- served_cnt increments by 1 on each rsp_valid && rsp_ready. It wraps from 2^32-1 to 0.
- ptr is unchanged when nothing is accepted.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants rotate 0,1,..,N_REQ-1,0,...
- Reset mid-operation: any held response is discarded (rsp_valid=0 on the next cycle), and ptr and served_cnt are cleared. req_ready=0 during the cycle rst is high.
- req_sel of non-granted requesters is ignored; the selector is sampled only at accept.

Decomposition:
- Shared package oak_pkg:
  - The five IEEE-754 constants.
  - Selector encodings SEL_PHI..SEL_PHOENIX.
  - SEL_W=3.
- Constant values come from an instance of oak_foundation, muxed by the winning selector.
- One sub-module: oak_rr_arbiter (parameter N; inputs req, ptr, en; outputs gnt one-hot and gnt_idx). It is purely combinational, so it can be tested standalone.

Test Plan:
1. Reset, then requester 2 asks for sel=1 with rsp_ready=1 -> req_ready=4'b0100 in the same cycle. Next cycle: rsp_valid=1, rsp_id=2, rsp_data=64'h400921FB54442D18, rsp_err=0. served_cnt=1 after the handshake.
2. All 4 requesters valid (sel=0,2,3,4), rsp_ready=1 for 8 cycles -> rsp_id sequence 0,1,2,3,0,1,2,3. rsp_data follows the map (phoenix = 64'd999). served_cnt=8.
3. Backpressure: rsp_ready=0 for 5 cycles after the first response -> rsp_valid, rsp_id and rsp_data are held. req_ready=0 throughout. On rsp_ready=1 a new grant occurs in the same cycle and rsp_valid stays high.
4. Requester 1 uses sel=6 -> rsp_err=1 and rsp_data=0. The counter still increments on the handshake.
5. rst asserted while rsp_valid=1 and served_cnt=3 -> the next cycle shows rsp_valid=0 and served_cnt=0. The first post-reset grant favours requester 0 when requesters 0 and 3 are both valid.
6. Counter wrap: force served_cnt to 32'hFFFFFFFF, complete one handshake -> served_cnt=0.

Source files
------------

// File: rtl/oak_pkg.sv
// Shared definitions for the oak constant server: IEEE-754 constants,
// selector encodings and the response-register state type.
package oak_pkg;

  localparam int unsigned SEL_W = 3;

  typedef enum logic [SEL_W-1:0] {
    SEL_PHI     = 3'd0,
    SEL_PI      = 3'd1,
    SEL_E       = 3'd2,
    SEL_TRINITY = 3'd3,
    SEL_PHOENIX = 3'd4
  } sel_e;

  localparam logic [63:0] C_PHI      = 64'h3FF9E3779B97F4A8;
  localparam logic [63:0] C_PI       = 64'h400921FB54442D18;
  localparam logic [63:0] C_E        = 64'h4005BF0A8B145769;
  localparam logic [63:0] C_TRINITY  = 64'h4008000000000000;
  localparam logic [31:0] PHOENIX_ID = 32'd999;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/oak_foundation.sv
// L1 sacred-constant source: presents the five foundation constants as
// static values for the layers above.
module oak_foundation
  import oak_pkg::*;
(
  output logic [63:0] o_phi,
  output logic [63:0] o_pi,
  output logic [63:0] o_e,
  output logic [63:0] o_trinity,
  output logic [31:0] o_phoenix_id
);

  assign o_phi        = C_PHI;
  assign o_pi         = C_PI;
  assign o_e          = C_E;
  assign o_trinity    = C_TRINITY;
  assign o_phoenix_id = PHOENIX_ID;

endmodule

// File: rtl/oak_rr_arbiter.sv
// Combinational round-robin arbiter: scans req from ptr upward, wrapping
// modulo N; the first set bit wins. gnt is gated by en.
module oak_rr_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx
);

  logic        w_found;
  int unsigned w_idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = (32'(ptr) + k) % N;
      if (!w_found && req[W'(w_idx)]) begin
        w_found = 1'b1;
        gnt_idx = W'(w_idx);
      end
    end
    if (en && w_found) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/oak_constant_server.sv
// Serves foundation constants to N_REQ requesters through a round-robin
// arbiter and a one-entry, back-pressurable response register.
module oak_constant_server
  import oak_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [SEL_W*N_REQ-1:0] req_sel,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [63:0]            rsp_data,
  output logic                   rsp_err,
  output logic [31:0]            served_cnt
);

  logic [63:0]      w_phi;
  logic [63:0]      w_pi;
  logic [63:0]      w_e;
  logic [63:0]      w_trinity;
  logic [31:0]      w_phoenix;

  logic [N_REQ-1:0] w_gnt;
  logic [ID_W-1:0]  w_gnt_idx;
  logic             w_acc_en;
  logic             w_arb_en;
  logic             w_accept;
  logic [SEL_W-1:0] w_sel;
  logic [63:0]      w_data;
  logic             w_err;

  rsp_state_e       r_state;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_rsp_id;
  logic [63:0]      r_rsp_data;
  logic             r_rsp_err;
  logic [31:0]      r_served_cnt;

  oak_foundation u_foundation (
    .o_phi        (w_phi),
    .o_pi         (w_pi),
    .o_e          (w_e),
    .o_trinity    (w_trinity),
    .o_phoenix_id (w_phoenix)
  );

  // Accepting while FULL is only legal when the held response leaves this cycle.
  assign w_acc_en = (r_state == RSP_EMPTY) || rsp_ready;
  assign w_arb_en = w_acc_en && !rst;

  oak_rr_arbiter #(
    .N (N_REQ),
    .W (ID_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (r_ptr),
    .en      (w_arb_en),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign req_ready = w_gnt;
  assign w_accept  = |w_gnt;

  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == w_gnt_idx) begin
        w_sel = req_sel[SEL_W*i +: SEL_W];
      end
    end
  end

  always_comb begin
    w_data = '0;
    w_err  = 1'b0;
    case (sel_e'(w_sel))
      SEL_PHI:     w_data = w_phi;
      SEL_PI:      w_data = w_pi;
      SEL_E:       w_data = w_e;
      SEL_TRINITY: w_data = w_trinity;
      SEL_PHOENIX: w_data = {32'd0, w_phoenix};
      default:     w_err  = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RSP_EMPTY;
      r_ptr        <= '0;
      r_rsp_id     <= '0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
      r_served_cnt <= '0;
    end else begin
      if ((r_state == RSP_FULL) && rsp_ready) begin
        r_served_cnt <= r_served_cnt + 32'd1;
      end
      if (w_accept) begin
        r_rsp_id   <= w_gnt_idx;
        r_rsp_data <= w_data;
        r_rsp_err  <= w_err;
        r_ptr      <= (32'(w_gnt_idx) == N_REQ - 1) ? '0 : w_gnt_idx + 1'b1;
      end
      case (r_state)
        RSP_EMPTY: if (w_accept) r_state <= RSP_FULL;
        RSP_FULL:  if (rsp_ready && !w_accept) r_state <= RSP_EMPTY;
        default:   r_state <= RSP_EMPTY;
      endcase
    end
  end

  assign rsp_valid  = (r_state == RSP_FULL);
  assign rsp_id     = r_rsp_id;
  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;
  assign served_cnt = r_served_cnt;

endmodule

// File: tb/tb_oak_constant_server.sv
// Directed bench for oak_constant_server: arbitration order, data map,
// backpressure, error selector, mid-operation reset and counter wrap.
module tb_oak_constant_server;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [11:0] req_sel;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic [31:0] served_cnt;

  int n_chk;
  int n_fail;

  localparam logic [63:0] K_PHI  = 64'h3FF9E3779B97F4A8;
  localparam logic [63:0] K_PI   = 64'h400921FB54442D18;
  localparam logic [63:0] K_E    = 64'h4005BF0A8B145769;
  localparam logic [63:0] K_TRI  = 64'h4008000000000000;
  localparam logic [63:0] K_PHX  = 64'd999;

  logic [63:0] exp_rot [4];

  oak_constant_server #(
    .N_REQ (4),
    .ID_W  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_sel    (req_sel),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .served_cnt (served_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    exp_rot[0] = K_PHI;
    exp_rot[1] = K_E;
    exp_rot[2] = K_TRI;
    exp_rot[3] = K_PHX;

    rst       = 1'b1;
    req_valid = 4'hF;
    req_sel   = '0;
    rsp_ready = 1'b0;

    // Reset state; req_ready must stay low while rst is high.
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    @(negedge clk);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_id", 64'(rsp_id), 64'd0);
    chk("rst_data", rsp_data, 64'd0);
    chk("rst_err", 64'(rsp_err), 64'd0);
    chk("rst_cnt", 64'(served_cnt), 64'd0);
    rst       = 1'b0;
    req_valid = 4'b0000;

    // Single request from requester 2, selector pi.
    @(negedge clk);
    req_valid = 4'b0100;
    req_sel   = {3'd0, 3'd1, 3'd0, 3'd0};
    rsp_ready = 1'b1;
    #1 chk("t1_req_ready", 64'(req_ready), 64'b0100);
    @(negedge clk);
    chk("t1_valid", 64'(rsp_valid), 64'd1);
    chk("t1_id", 64'(rsp_id), 64'd2);
    chk("t1_data", rsp_data, K_PI);
    chk("t1_err", 64'(rsp_err), 64'd0);
    req_valid = 4'b0000;
    @(negedge clk);
    chk("t1_cnt", 64'(served_cnt), 64'd1);
    chk("t1_empty", 64'(rsp_valid), 64'd0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // All four requesters valid, continuous rsp_ready: strict rotation.
    req_valid = 4'hF;
    req_sel   = {3'd4, 3'd3, 3'd2, 3'd0};
    #1 chk("t2_first_gnt", 64'(req_ready), 64'b0001);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("t2_valid_%0d", i), 64'(rsp_valid), 64'd1);
      chk($sformatf("t2_id_%0d", i), 64'(rsp_id), 64'(i % 4));
      chk($sformatf("t2_data_%0d", i), rsp_data, exp_rot[i % 4]);
      chk($sformatf("t2_cnt_%0d", i), 64'(served_cnt), 64'(i));
      if (i == 7) begin
        req_valid = 4'b0000;
      end else begin
        #1 chk($sformatf("t2_gnt_%0d", i), 64'(req_ready), 64'(1 << ((i + 1) % 4)));
      end
    end
    @(negedge clk);
    chk("t2_cnt_final", 64'(served_cnt), 64'd8);
    chk("t2_empty", 64'(rsp_valid), 64'd0);

    // Backpressure: response held, no grants, then overwrite on release.
    req_valid = 4'b0010;
    #1 chk("t3_gnt", 64'(req_ready), 64'b0010);
    @(negedge clk);
    chk("t3_id", 64'(rsp_id), 64'd1);
    chk("t3_data", rsp_data, K_E);
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    #1 chk("t3_block", 64'(req_ready), 64'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t3_hold_valid_%0d", i), 64'(rsp_valid), 64'd1);
      chk($sformatf("t3_hold_id_%0d", i), 64'(rsp_id), 64'd1);
      chk($sformatf("t3_hold_data_%0d", i), rsp_data, K_E);
      chk($sformatf("t3_hold_rdy_%0d", i), 64'(req_ready), 64'h0);
      chk($sformatf("t3_hold_cnt_%0d", i), 64'(served_cnt), 64'd8);
    end
    rsp_ready = 1'b1;
    #1 chk("t3_regrant", 64'(req_ready), 64'b0100);
    @(negedge clk);
    chk("t3_valid", 64'(rsp_valid), 64'd1);
    chk("t3_new_id", 64'(rsp_id), 64'd2);
    chk("t3_new_data", rsp_data, K_TRI);
    chk("t3_cnt", 64'(served_cnt), 64'd9);
    req_valid = 4'b0000;
    @(negedge clk);
    chk("t3_cnt_final", 64'(served_cnt), 64'd10);

    // Out-of-range selector on requester 1.
    req_valid = 4'b0010;
    req_sel   = {3'd4, 3'd3, 3'd6, 3'd0};
    #1 chk("t4_gnt", 64'(req_ready), 64'b0010);
    @(negedge clk);
    chk("t4_valid", 64'(rsp_valid), 64'd1);
    chk("t4_id", 64'(rsp_id), 64'd1);
    chk("t4_err", 64'(rsp_err), 64'd1);
    chk("t4_data", rsp_data, 64'd0);
    req_valid = 4'b0000;
    @(negedge clk);
    chk("t4_cnt", 64'(served_cnt), 64'd11);

    // Reset while a response is held with served_cnt = 3.
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 4'b0001;
    repeat (4) @(negedge clk);
    chk("t5_pre_cnt", 64'(served_cnt), 64'd3);
    chk("t5_pre_valid", 64'(rsp_valid), 64'd1);
    rst       = 1'b1;
    req_valid = 4'b1001;
    #1 chk("t5_rst_rdy", 64'(req_ready), 64'h0);
    @(negedge clk);
    chk("t5_valid", 64'(rsp_valid), 64'd0);
    chk("t5_cnt", 64'(served_cnt), 64'd0);
    rst = 1'b0;
    #1 chk("t5_gnt", 64'(req_ready), 64'b0001);
    @(negedge clk);
    chk("t5_id", 64'(rsp_id), 64'd0);
    chk("t5_data", rsp_data, K_PHI);
    req_valid = 4'b0000;
    @(negedge clk);
    chk("t5_cnt_after", 64'(served_cnt), 64'd1);

    // Counter wrap from all-ones.
    force dut.r_served_cnt = 32'hFFFFFFFF;
    #1;
    release dut.r_served_cnt;
    chk("t6_forced", 64'(served_cnt), 64'hFFFFFFFF);
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0000;
    chk("t6_valid", 64'(rsp_valid), 64'd1);
    chk("t6_cnt_hold", 64'(served_cnt), 64'hFFFFFFFF);
    @(negedge clk);
    chk("t6_wrap", 64'(served_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
